// File: rtl/qround_pkg.sv
// Shared types for the fixed-point rounding pipeline: rounding modes and
// the parameter legality check used at elaboration.
package qround_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    TRUNC     = 2'b00,
    HALF_UP   = 2'b01,
    HALF_EVEN = 2'b10,
    HALF_AWAY = 2'b11
  } mode_t;

  function automatic bit params_ok(input int in_w, input int in_f,
                                   input int out_w, input int out_f,
                                   input int cnt_w);
    return (out_f >= 0) && (out_f < in_f) && (out_w >= 1) && (cnt_w >= 1) &&
           (out_w - out_f <= in_w - in_f);
  endfunction

endpackage

// File: rtl/qround_core.sv
// Combinational rounding (feeding S1) and clipping of the S1 value (feeding S2)
// for the fixed-point narrowing pipeline.
module qround_core
  import qround_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int IN_F   = 4,
  parameter int OUT_W  = 4,
  parameter int OUT_F  = 0,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic [IN_W-1:0]   data,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  rnd,
  output logic              ovf,
  output logic              unf,
  input  logic [OUT_W-1:0]  s1_rnd,
  input  logic              s1_ovf,
  input  logic              s1_unf,
  output logic [OUT_W-1:0]  res,
  output logic              sat
);

  localparam int SHIFT = IN_F - OUT_F;
  localparam int RW    = IN_W - SHIFT + 1;

  if (!params_ok(IN_W, IN_F, OUT_W, OUT_F, CNT_W)) begin : g_bad_params
    $fatal(1, "qround_core: illegal parameter set");
  end

  localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
  localparam logic [OUT_W-1:0] MAXV = {OUT_W{1'b1}} >> ((SIGNED != 0) ? 1 : 0);
  localparam logic [OUT_W-1:0] MINV = (SIGNED != 0) ? ~MAXV : '0;

  logic [RW-1:0]    flx;
  logic [RW-1:0]    sum;
  logic [SHIFT-1:0] rem;
  logic             neg;
  logic             gt;
  logic             eq;
  logic             inc;

  // One guard bit above the floored value keeps the rounding carry.
  assign neg = (SIGNED != 0) && data[IN_W-1];
  assign flx = {neg, data[IN_W-1:SHIFT]};
  assign rem = data[SHIFT-1:0];

  always_comb begin
    gt  = rem > HALF;
    eq  = rem == HALF;
    inc = 1'b0;
    case (mode_t'(mode))
      TRUNC:     inc = 1'b0;
      HALF_UP:   inc = gt | eq;
      HALF_EVEN: inc = gt | (eq & flx[0]);
      HALF_AWAY: inc = neg ? gt : (gt | eq);
      default:   inc = 1'b0;
    endcase
    sum = flx + RW'(inc);
    if (SIGNED != 0) begin
      ovf = ~sum[RW-1] & (|sum[RW-2:OUT_W-1]);
      unf = sum[RW-1] & ~(&sum[RW-2:OUT_W-1]);
    end else begin
      ovf = |sum[RW-1:OUT_W];
      unf = 1'b0;
    end
    rnd = sum[OUT_W-1:0];
  end

  always_comb begin
    sat = s1_ovf | s1_unf;
    if (s1_ovf)      res = MAXV;
    else if (s1_unf) res = MINV;
    else             res = s1_rnd;
  end

endmodule

// File: rtl/qround_pipe.sv
// Two-stage valid/ready pipeline that rounds and clips a fixed-point sample,
// and counts the clipped results delivered downstream.
module qround_pipe
  import qround_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int IN_F   = 4,
  parameter int OUT_W  = 4,
  parameter int OUT_F  = 0,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sat_cnt
);

  logic             s1_valid;
  logic [OUT_W-1:0] s1_rnd;
  logic             s1_ovf;
  logic             s1_unf;
  logic             s2_valid;
  logic             s1_adv;
  logic [OUT_W-1:0] c_rnd;
  logic             c_ovf;
  logic             c_unf;
  logic [OUT_W-1:0] c_res;
  logic             c_sat;

  qround_core #(
    .IN_W  (IN_W),
    .IN_F  (IN_F),
    .OUT_W (OUT_W),
    .OUT_F (OUT_F),
    .SIGNED(SIGNED),
    .CNT_W (CNT_W)
  ) u_core (
    .data  (in_data),
    .mode  (in_mode),
    .rnd   (c_rnd),
    .ovf   (c_ovf),
    .unf   (c_unf),
    .s1_rnd(s1_rnd),
    .s1_ovf(s1_ovf),
    .s1_unf(s1_unf),
    .res   (c_res),
    .sat   (c_sat)
  );

  assign s1_adv    = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rnd   <= '0;
      s1_ovf   <= 1'b0;
      s1_unf   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_rnd <= c_rnd;
        s1_ovf <= c_ovf;
        s1_unf <= c_unf;
      end
    end
  end

  // Result registers only load on a real sample so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= c_res;
        out_sat  <= c_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (s2_valid && out_ready && out_sat && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_qround_pipe.sv
// Directed bench for qround_pipe: unsigned, signed and narrow-counter instances
// driven from shared stimulus.
module tb_qround_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_ready;
  logic       cnt_clr;

  logic        u_ready, u_valid, u_sat;
  logic [3:0]  u_data;
  logic [15:0] u_cnt;
  logic        s_ready, s_valid, s_sat;
  logic [3:0]  s_data;
  logic [15:0] s_cnt;
  logic        c_ready, c_valid, c_sat;
  logic [3:0]  c_data;
  logic [1:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  qround_pipe dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(u_valid),
    .out_ready(out_ready), .out_data(u_data), .out_sat(u_sat),
    .cnt_clr(cnt_clr), .sat_cnt(u_cnt)
  );

  qround_pipe #(.SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(s_valid),
    .out_ready(out_ready), .out_data(s_data), .out_sat(s_sat),
    .cnt_clr(cnt_clr), .sat_cnt(s_cnt)
  );

  qround_pipe #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(c_valid),
    .out_ready(out_ready), .out_data(c_data), .out_sat(c_sat),
    .cnt_clr(cnt_clr), .sat_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer floor/remainder, then clamp to the 4-bit output range.
  function automatic logic [4:0] model(input logic [7:0] d, input logic [1:0] m, input bit sgn);
    int v, fl, rem, r, lo, hi;
    bit up;
    v   = sgn ? int'($signed(d)) : int'(d);
    fl  = v >>> 4;
    rem = v & 15;
    case (m)
      2'd0:    up = 1'b0;
      2'd1:    up = rem >= 8;
      2'd2:    up = (rem > 8) || (rem == 8 && (fl & 1) == 1);
      default: up = (sgn && v < 0) ? (rem > 8) : (rem >= 8);
    endcase
    r  = fl + int'(up);
    lo = sgn ? -8 : 0;
    hi = sgn ? 7 : 15;
    if (r > hi)      return {1'b1, 4'(hi)};
    else if (r < lo) return {1'b1, 4'(lo)};
    else             return {1'b0, 4'(r)};
  endfunction

  task automatic send_chk(input string tag, input logic [7:0] d, input logic [1:0] m,
                          input logic [3:0] eu, input logic su,
                          input logic [3:0] es, input logic ss);
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(u_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_mode  = ~m;
    chk({tag, ".lat1_valid"}, 32'(u_valid), 32'd0);
    tick();
    chk({tag, ".lat2_valid"}, 32'(u_valid), 32'd1);
    chk({tag, ".u_data"}, 32'(u_data), 32'(eu));
    chk({tag, ".u_sat"}, 32'(u_sat), 32'(su));
    chk({tag, ".s_data"}, 32'(s_data), 32'(es));
    chk({tag, ".s_sat"}, 32'(s_sat), 32'(ss));
    tick();
  endtask

  initial begin
    logic [9:0] q[$];
    logic [9:0] head;
    logic [4:0] mu, ms;
    int sent, rcvd, cyc, exp_ucnt, exp_scnt;
    logic [3:0] held;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(u_valid), 32'd0);
    chk("rst.out_data", 32'(u_data), 32'd0);
    chk("rst.out_sat", 32'(u_sat), 32'd0);
    chk("rst.sat_cnt", 32'(u_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", 32'(u_ready), 32'd1);
    tick();

    send_chk("2.5_trunc",     8'h28, 2'd0, 4'd2, 1'b0, 4'd2, 1'b0);
    send_chk("2.5_half_up",   8'h28, 2'd1, 4'd3, 1'b0, 4'd3, 1'b0);
    send_chk("2.5_half_even", 8'h28, 2'd2, 4'd2, 1'b0, 4'd2, 1'b0);
    send_chk("2.5_half_away", 8'h28, 2'd3, 4'd3, 1'b0, 4'd3, 1'b0);
    send_chk("3.5_half_even", 8'h38, 2'd2, 4'd4, 1'b0, 4'd4, 1'b0);
    send_chk("f8_half_up",    8'hF8, 2'd1, 4'hF, 1'b1, 4'h0, 1'b0);
    chk("f8.u_sat_cnt", 32'(u_cnt), 32'd1);
    send_chk("ff_trunc",      8'hFF, 2'd0, 4'hF, 1'b0, 4'hF, 1'b0);
    send_chk("d8_half_up",    8'hD8, 2'd1, 4'hE, 1'b0, 4'hE, 1'b0);
    send_chk("d8_half_away",  8'hD8, 2'd3, 4'hE, 1'b0, 4'hD, 1'b0);
    send_chk("d8_half_even",  8'hD8, 2'd2, 4'hE, 1'b0, 4'hE, 1'b0);
    send_chk("d8_trunc",      8'hD8, 2'd0, 4'hD, 1'b0, 4'hD, 1'b0);
    send_chk("78_half_up",    8'h78, 2'd1, 4'h8, 1'b0, 4'h7, 1'b1);
    send_chk("80_trunc",      8'h80, 2'd0, 4'h8, 1'b0, 4'h8, 1'b0);
    send_chk("7f_half_away",  8'h7F, 2'd3, 4'h8, 1'b0, 4'h7, 1'b1);
    chk("tbl.u_sat_cnt", 32'(u_cnt), 32'd1);
    chk("tbl.s_sat_cnt", 32'(s_cnt), 32'd2);
    chk("tbl.c_sat_cnt", 32'(c_cnt), 32'd1);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr.u_sat_cnt", 32'(u_cnt), 32'd0);
    chk("clr.s_sat_cnt", 32'(s_cnt), 32'd0);
    chk("clr.c_sat_cnt", 32'(c_cnt), 32'd0);

    // Five clipped results back-to-back: the 2-bit counter must stick at 3.
    in_valid = 1'b1; in_data = 8'hF8; in_mode = 2'd1; out_ready = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("burst.c_sat_cnt", 32'(c_cnt), 32'd3);
    chk("burst.u_sat_cnt", 32'(u_cnt), 32'd5);
    chk("burst.s_sat_cnt", 32'(s_cnt), 32'd0);

    // Park a clipped result, check it holds, then clear on its transfer edge.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hF8; in_mode = 2'd1;
    tick();
    in_valid = 1'b0; in_data = 8'h00; in_mode = 2'd0;
    tick();
    chk("park.valid", 32'(c_valid), 32'd1);
    chk("park.sat", 32'(c_sat), 32'd1);
    held = c_data;
    tick();
    chk("park.hold_valid", 32'(c_valid), 32'd1);
    chk("park.hold_data", 32'(c_data), 32'hF);
    chk("park.hold_same", 32'(c_data), 32'(held));
    out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_coinc.c_sat_cnt", 32'(c_cnt), 32'd0);
    chk("clr_coinc.u_sat_cnt", 32'(u_cnt), 32'd0);
    chk("clr_coinc.valid", 32'(c_valid), 32'd0);

    sent = 0; rcvd = 0; cyc = 0; exp_ucnt = 0; exp_scnt = 0;
    while (rcvd < 256 && cyc < 4000) begin
      in_valid  = (sent < 256) && ($urandom_range(0, 3) != 0);
      in_data   = 8'(sent);
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (u_valid) begin
        if (q.size() == 0) begin
          chk("stream.spurious", 32'd1, 32'd0);
        end else begin
          head = q[0];
          chk("stream.u_data", 32'(u_data), 32'(head[8:5]));
          chk("stream.u_sat", 32'(u_sat), 32'(head[9]));
          chk("stream.s_data", 32'(s_data), 32'(head[3:0]));
          chk("stream.s_sat", 32'(s_sat), 32'(head[4]));
          if (out_ready) begin
            void'(q.pop_front());
            rcvd++;
            exp_ucnt += int'(head[9]);
            exp_scnt += int'(head[4]);
          end
        end
      end
      if (in_valid && u_ready) begin
        mu = model(in_data, in_mode, 1'b0);
        ms = model(in_data, in_mode, 1'b1);
        q.push_back({mu, ms});
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream.delivered", 32'(rcvd), 32'd256);
    chk("stream.u_sat_cnt", 32'(u_cnt), 32'(exp_ucnt));
    chk("stream.s_sat_cnt", 32'(s_cnt), 32'(exp_scnt));

    // Two samples in flight, then asynchronous reset mid-cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hF8; in_mode = 2'd1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("flight.valid", 32'(u_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", 32'(u_valid), 32'd0);
    chk("arst.u_sat_cnt", 32'(u_cnt), 32'd0);
    chk("arst.s_sat_cnt", 32'(s_cnt), 32'd0);
    chk("arst.out_data", 32'(u_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst.in_ready", 32'(u_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst.no_stale", 32'(u_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
